// File: rtl/exec_pkg.sv
// Shared types for the execute stage: op codes, condition codes, NZCV
// bundle, multiplier FSM states and the branch-condition evaluator.
package exec_pkg;

  typedef enum logic [2:0] {
    OP_PASSB = 3'b000,
    OP_RSVD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_MUL   = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000,
    CC_NE = 4'b0001,
    CC_HS = 4'b0010,
    CC_LO = 4'b0011,
    CC_MI = 4'b0100,
    CC_PL = 4'b0101,
    CC_VS = 4'b0110,
    CC_VC = 4'b0111,
    CC_HI = 4'b1000,
    CC_LS = 4'b1001,
    CC_GE = 4'b1010,
    CC_LT = 4'b1011,
    CC_GT = 4'b1100,
    CC_LE = 4'b1101,
    CC_AL = 4'b1110,
    CC_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } exec_state_e;

  function automatic logic cond_eval(
    input nzcv_t f,
    input cond_e cc
  );
    logic ge;
    logic gt;
    logic r;
    ge = (f.n == f.v);
    gt = !f.z && ge;
    case (cc)
      CC_EQ:   r = f.z;
      CC_NE:   r = !f.z;
      CC_HS:   r = f.c;
      CC_LO:   r = !f.c;
      CC_MI:   r = f.n;
      CC_PL:   r = !f.n;
      CC_VS:   r = f.v;
      CC_VC:   r = !f.v;
      CC_HI:   r = f.c && !f.z;
      CC_LS:   r = !(f.c && !f.z);
      CC_GE:   r = ge;
      CC_LT:   r = !ge;
      CC_GT:   r = gt;
      CC_LE:   r = !gt;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_unit_p_mul_iter.sv
// Iterative shift-add multiplier, MUL_BITS_PC multiplier bits per cycle.
// Produces the low WIDTH bits of the unsigned product.
import exec_pkg::*;

module mul_iter #(
  parameter int WIDTH       = 64,
  parameter int MUL_BITS_PC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int MUL_CYC = WIDTH / MUL_BITS_PC;
  localparam int CW      = $clog2(MUL_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYC - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_BITS_PC; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  assign acc_d   = acc_q + pp;
  assign done    = busy && (cnt_q == LAST);
  assign product = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (busy) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << MUL_BITS_PC;
      mplier_q <= mplier_q >> MUL_BITS_PC;
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        busy  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/exec_unit_p.sv
// Execute stage: ALU-src mux, ALU, NZCV register, B.cond, registered result.
// EXEC_MUL_EN adds the iterative multiplier and IDLE/MUL/DONE issue FSM.
import exec_pkg::*;

module exec_unit_p #(
  parameter int WIDTH       = 64,
  parameter int MUL_BITS_PC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ex_da,
  input  logic [WIDTH-1:0] ex_db,
  input  logic [WIDTH-1:0] ex_imm,
  input  logic             ex_alu_src,
  input  logic [2:0]       ex_alu_op,
  input  logic             ex_flag_write,
  input  logic             ex_is_bcond,
  input  logic [3:0]       ex_cond,
  output logic             out_valid,
  output logic [WIDTH-1:0] ex_result,
  output logic [3:0]       flags_q,
  output logic             br_taken
);

  alu_op_e          op;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] alu_res;
  nzcv_t            alu_f;
  logic             accept;
  logic             issue_1c;
  logic             br_eval;

  assign op      = alu_op_e'(ex_alu_op);
  assign op_b    = ex_alu_src ? ex_imm : ex_db;
  assign add_sum = {1'b0, ex_da} + {1'b0, op_b};
  assign sub_sum = {1'b0, ex_da} + {1'b0, ~op_b}
                 + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_f   = '0;
    case (op)
      OP_PASSB: alu_res = op_b;
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_f.c = add_sum[WIDTH];
        alu_f.v = (ex_da[WIDTH-1] == op_b[WIDTH-1])
               && (alu_res[WIDTH-1] != ex_da[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_f.c = sub_sum[WIDTH];
        alu_f.v = (ex_da[WIDTH-1] != op_b[WIDTH-1])
               && (alu_res[WIDTH-1] != ex_da[WIDTH-1]);
      end
      OP_AND:  alu_res = ex_da & op_b;
      OP_OR:   alu_res = ex_da | op_b;
      OP_XOR:  alu_res = ex_da ^ op_b;
      default: alu_res = '0;
    endcase
    alu_f.n = alu_res[WIDTH-1];
    alu_f.z = (alu_res == '0);
  end

  assign accept  = in_valid && in_ready;
  // Condition sees committed flags only; the branch's own flags land later.
  assign br_eval = ex_is_bcond
                && cond_eval(nzcv_t'(flags_q), cond_e'(ex_cond));

`ifdef EXEC_MUL_EN
  exec_state_e      state_q;
  exec_state_e      state_d;
  logic             fw_q;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic             mul_fin;
  logic [WIDTH-1:0] mul_prod;

  assign mul_start = accept && (op == OP_MUL);
  assign mul_fin   = (state_q == MUL) && mul_done;
  assign issue_1c  = accept && !mul_start;
  assign in_ready  = !reset && !mul_busy;

  mul_iter #(
    .WIDTH       (WIDTH),
    .MUL_BITS_PC (MUL_BITS_PC)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (ex_da),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done) state_d = DONE;
      DONE:    state_d = mul_start ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
`else
  assign issue_1c = accept;
  assign in_ready = !reset;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ex_result <= '0;
      flags_q   <= '0;
      br_taken  <= 1'b0;
`ifdef EXEC_MUL_EN
      fw_q      <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      br_taken  <= 1'b0;
`ifdef EXEC_MUL_EN
      if (mul_start) fw_q <= ex_flag_write;
      if (mul_fin) begin
        out_valid <= 1'b1;
        ex_result <= mul_prod;
        if (fw_q) begin
          flags_q <= {mul_prod[WIDTH-1], mul_prod == '0, 2'b00};
        end
      end
`endif
      if (issue_1c) begin
        out_valid <= 1'b1;
        ex_result <= alu_res;
        br_taken  <= br_eval;
        if (ex_flag_write) flags_q <= alu_f;
      end
    end
  end

endmodule
